spi_txn_arbiter: RTL and testbench

Round-robin arbiter and transaction sequencer that shares the single SPI master among NREQ requesters. Each requester posts a one-byte transfer (target slave select, read/write, SPI mode, write byte). The block grants one request at a time, drives the master's CS/RW/MODE/data controls with a start pulse, waits for completion or timeout, and returns the read byte and status to the granted requester. It sits between the system-side requesters and the SPI master inside the SPI protocol top.

---
 rtl/spi_txn_arbiter.sv | 173 +++++++++++++++++
 tb/tb_spi_txn_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: shares one SPI master among NREQ requesters.
// A round-robin pick in IDLE loads the granted requester's transfer fields
// into the master-facing output registers. The block then issues a one-cycle
// start and waits for done or timeout. It returns the read byte and the status
// to that requester with a one-cycle ack.
module spi_txn_arbiter #(
  parameter int NREQ    = 3,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        req_cs,
  input  logic [2*NREQ-1:0]        req_rw,
  input  logic [2*NREQ-1:0]        req_mode,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     busy,
  output logic                     m_start,
  output logic [1:0]               m_cs,
  output logic [1:0]               m_rw,
  output logic [1:0]               m_mode,
  output logic [DATA_W-1:0]        m_wdata,
  input  logic                     m_done,
  input  logic [DATA_W-1:0]        m_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t          state_r;
  logic [PW-1:0]   ptr_r;
  logic [PW-1:0]   gnt_r;
  logic [CW-1:0]   cnt_r;

  logic            win_found_s;
  logic [PW-1:0]   win_idx_s;
  logic [1:0]      win_cs_s;
  logic [1:0]      win_rw_s;
  logic [1:0]      win_mode_s;
  logic [DATA_W-1:0] win_wdata_s;

  // Index reached by stepping 'off' places upward from 'base', wrapping at NREQ.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    sum = (sum >= NREQ) ? (sum - NREQ) : sum;
    return PW'(sum);
  endfunction

  // One-hot ack vector for requester idx.
  function automatic logic [NREQ-1:0] grant_onehot(input logic [PW-1:0] idx);
    return {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Pointer value after serving idx: the next requester up, wrapping to 0.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] idx);
    return (idx == PW'(NREQ - 1)) ? {PW{1'b0}} : (idx + {{(PW-1){1'b0}}, 1'b1});
  endfunction

  // Round-robin winner: the loop scans from the farthest offset down to the
  // pointer, so the closest requester at or above ptr overwrites the others.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {PW{1'b0}};
    for (int off = NREQ - 1; off >= 0; off--) begin
      win_found_s = win_found_s | req[rr_index(ptr_r, off)];
      win_idx_s   = req[rr_index(ptr_r, off)] ? rr_index(ptr_r, off) : win_idx_s;
    end
  end

  assign win_cs_s    = req_cs[2*win_idx_s +: 2];
  assign win_rw_s    = req_rw[2*win_idx_s +: 2];
  assign win_mode_s  = req_mode[2*win_idx_s +: 2];
  assign win_wdata_s = req_wdata[DATA_W*win_idx_s +: DATA_W];

  // Transaction FSM with registered outputs. The m_* registers double as the
  // holding registers for the granted transfer, so they stay stable through WAIT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      ptr_r     <= {PW{1'b0}};
      gnt_r     <= {PW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      ack       <= {NREQ{1'b0}};
      rsp_rdata <= {DATA_W{1'b0}};
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_cs      <= 2'b00;
      m_rw      <= 2'b00;
      m_mode    <= 2'b00;
      m_wdata   <= {DATA_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          ack     <= {NREQ{1'b0}};
          m_start <= 1'b0;
          if (win_found_s) begin
            gnt_r   <= win_idx_s;
            busy    <= 1'b1;
            m_rw    <= win_rw_s;
            m_mode  <= win_mode_s;
            m_wdata <= win_wdata_s;
            if (win_cs_s == 2'b00) begin
              // No slave selected: answer with an error without touching the master.
              state_r   <= ST_RESP;
              ack       <= grant_onehot(win_idx_s);
              rsp_err   <= 1'b1;
              rsp_rdata <= {DATA_W{1'b0}};
              m_cs      <= 2'b00;
            end else begin
              state_r <= ST_ISSUE;
              m_start <= 1'b1;
              m_cs    <= win_cs_s;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        ST_ISSUE: begin
          m_start <= 1'b0;
          cnt_r   <= {CW{1'b0}};
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          cnt_r <= (cnt_r == {CW{1'b1}}) ? cnt_r : (cnt_r + {{(CW-1){1'b0}}, 1'b1});
          if (m_done) begin
            // Completion wins over a timeout landing in the same cycle.
            state_r   <= ST_RESP;
            ack       <= grant_onehot(gnt_r);
            rsp_rdata <= m_rdata;
            rsp_err   <= 1'b0;
            m_cs      <= 2'b00;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            // This is the TIMEOUT-th cycle spent in WAIT.
            state_r   <= ST_RESP;
            ack       <= grant_onehot(gnt_r);
            rsp_rdata <= {DATA_W{1'b0}};
            rsp_err   <= 1'b1;
            m_cs      <= 2'b00;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_RESP: begin
          ack     <= {NREQ{1'b0}};
          busy    <= 1'b0;
          ptr_r   <= next_ptr(gnt_r);
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          ack     <= {NREQ{1'b0}};
          busy    <= 1'b0;
          m_start <= 1'b0;
          m_cs    <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter. The bench predicts grant order,
// latency and response values from the transaction rules with a small reference model.
module tb_spi_txn_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 8;
  localparam int TO   = 255;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_cs, req_rw, req_mode;
  logic [DW*NREQ-1:0] req_wdata;
  logic [NREQ-1:0]   ack;
  logic [DW-1:0]     rsp_rdata;
  logic              rsp_err, busy, m_start;
  logic [1:0]        m_cs, m_rw, m_mode;
  logic [DW-1:0]     m_wdata;
  logic              m_done;
  logic [DW-1:0]     m_rdata;

  int vectors = 0;
  int miscompares = 0;
  int mdl_ptr = 0;

  logic [1:0]    f_cs[NREQ];
  logic [1:0]    f_rw[NREQ];
  logic [1:0]    f_mode[NREQ];
  logic [DW-1:0] f_wd[NREQ];

  typedef struct {
    int start_cnt; int start_n; int ack_cnt; int ack_n;
    logic [1:0] s_cs; logic [1:0] s_rw; logic [1:0] s_mode; logic [DW-1:0] s_wdata;
    logic busy_at_start; logic hold_ok;
    logic [NREQ-1:0] ack_v; logic [DW-1:0] rdata; logic err; logic [1:0] cs_at_ack;
    logic busy_after; logic [1:0] cs_after;
  } obs_t;

  spi_txn_arbiter #(.NREQ(NREQ), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_cs(req_cs), .req_rw(req_rw),
    .req_mode(req_mode), .req_wdata(req_wdata), .ack(ack), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy), .m_start(m_start), .m_cs(m_cs), .m_rw(m_rw),
    .m_mode(m_mode), .m_wdata(m_wdata), .m_done(m_done), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; req = '0; m_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
    mdl_ptr = 0;
  endtask

  task automatic set_fields(input int i, input logic [1:0] cs, input logic [1:0] rw,
                            input logic [1:0] mode, input logic [DW-1:0] wd);
    f_cs[i] = cs; f_rw[i] = rw; f_mode[i] = mode; f_wd[i] = wd;
    req_cs[2*i +: 2] = cs; req_rw[2*i +: 2] = rw; req_mode[2*i +: 2] = mode;
    req_wdata[DW*i +: DW] = wd;
  endtask

  // Reference: first pending requester at or above the pointer, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int ptr);
    for (int i = 0; i < NREQ; i++) begin
      if (mask[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
    end
    return -1;
  endfunction

  // Drives the master side and records what the DUT does for one transaction.
  // Cycle n=1 is the first cycle after the edge that sees the request.
  task automatic run_txn(input bit keep_req, input int dly, input logic [DW-1:0] rd,
                         input int scr, input int budget, output obs_t o);
    int cd; int n; bit post; bit fin;
    o = '{default: 0};
    o.ack_n = -1; o.start_n = -1; o.hold_ok = 1'b1;
    cd = -1; n = 0; post = 0; fin = 0;
    while (!fin && n < budget) begin
      tick();
      n++;
      m_done = 1'b0;
      m_rdata = DW'($urandom);
      if (post) begin
        o.busy_after = busy; o.cs_after = m_cs;
        if (ack != '0) o.ack_cnt++;
        fin = 1;
      end else if (ack != '0) begin
        o.ack_cnt++; o.ack_n = n; o.ack_v = ack; o.rdata = rsp_rdata;
        o.err = rsp_err; o.cs_at_ack = m_cs;
        if (!keep_req) req = req & ~ack;
        post = 1;
      end else if (o.start_cnt > 0 && !m_start) begin
        if (m_cs !== o.s_cs || m_rw !== o.s_rw || m_mode !== o.s_mode ||
            m_wdata !== o.s_wdata || busy !== 1'b1) o.hold_ok = 1'b0;
      end
      if (m_start) begin
        o.start_cnt++;
        if (o.start_cnt == 1) begin
          o.start_n = n; o.s_cs = m_cs; o.s_rw = m_rw; o.s_mode = m_mode;
          o.s_wdata = m_wdata; o.busy_at_start = busy;
          cd = dly;
          if (scr >= 0) begin
            req_cs[2*scr +: 2] = 2'($urandom); req_rw[2*scr +: 2] = 2'($urandom);
            req_mode[2*scr +: 2] = 2'($urandom); req_wdata[DW*scr +: DW] = DW'($urandom);
          end
        end
      end else if (cd > 0) begin
        cd = cd - 1;
      end
      if (cd == 0 && o.start_cnt > 0 && !m_start) begin
        m_done = 1'b1; m_rdata = rd; cd = -1;
      end
    end
    m_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({ack, rsp_rdata, rsp_err, busy, m_start} !== '0) begin
      $display("FAIL reset_rsp: ack=%b rdata=%h err=%b busy=%b start=%b required all 0",
               ack, rsp_rdata, rsp_err, busy, m_start); miscompares++;
    end
    vectors++;
    if ({m_cs, m_rw, m_mode, m_wdata} !== '0) begin
      $display("FAIL reset_master: cs=%b rw=%b mode=%b wdata=%h required all 0",
               m_cs, m_rw, m_mode, m_wdata); miscompares++;
    end
  endtask

  task automatic test_single();
    obs_t o;
    set_fields(0, 2'b01, 2'b01, 2'b00, 8'hA5);
    req = 3'b001;
    run_txn(1'b0, 2, 8'h3C, 0, 50, o);
    vectors++;
    if (o.start_cnt !== 1 || o.start_n !== 1 || o.s_cs !== 2'b01 || o.s_wdata !== 8'hA5 || o.s_rw !== 2'b01) begin
      $display("FAIL single_start: cnt=%0d n=%0d cs=%b wdata=%h rw=%b required 1 1 01 a5 01",
               o.start_cnt, o.start_n, o.s_cs, o.s_wdata, o.s_rw); miscompares++;
    end
    vectors++;
    if (o.ack_n !== 4 || o.ack_v !== 3'b001 || o.rdata !== 8'h3C || o.err !== 1'b0) begin
      $display("FAIL single_ack: n=%0d ack=%b rdata=%h err=%b required 4 001 3c 0",
               o.ack_n, o.ack_v, o.rdata, o.err); miscompares++;
    end
    vectors++;
    if (o.cs_at_ack !== 2'b00 || o.busy_after !== 1'b0 || o.cs_after !== 2'b00 ||
        o.hold_ok !== 1'b1 || o.busy_at_start !== 1'b1 || o.ack_cnt !== 1) begin
      $display("FAIL single_misc: cs_ack=%b busy_after=%b cs_after=%b hold=%b busy_start=%b acks=%0d required 00 0 00 1 1 1",
               o.cs_at_ack, o.busy_after, o.cs_after, o.hold_ok, o.busy_at_start, o.ack_cnt); miscompares++;
    end
    mdl_ptr = 1;
  endtask

  task automatic test_fairness();
    obs_t o; int g; logic [DW-1:0] rd;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_fields(i, 2'(i + 1), 2'($urandom), 2'($urandom), DW'($urandom));
    req = 3'b111;
    for (int t = 0; t < 6; t++) begin
      g = rr_pick(req, mdl_ptr);
      rd = DW'($urandom);
      run_txn(1'b1, int'($urandom_range(1, 5)), rd, -1, 50, o);
      vectors++;
      if (g !== t % NREQ || o.ack_v !== (3'b001 << g) || o.s_cs !== f_cs[g] ||
          o.s_wdata !== f_wd[g] || o.rdata !== rd) begin
        $display("FAIL fairness_%0d: ack=%b cs=%b wdata=%h rdata=%h required ack=%b cs=%b wdata=%h rdata=%h",
                 t, o.ack_v, o.s_cs, o.s_wdata, o.rdata, 3'b001 << g, f_cs[g], f_wd[g], rd); miscompares++;
      end
      mdl_ptr = (g + 1) % NREQ;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    obs_t o;
    set_fields(0, 2'b10, 2'b00, 2'b11, 8'h5E);
    req = 3'b001;
    run_txn(1'b0, -1, 8'h00, -1, 2*TO, o);
    vectors++;
    if (o.start_cnt !== 1 || o.ack_n !== TO + 2 || o.ack_v !== 3'b001 || o.err !== 1'b1 || o.rdata !== 8'h00) begin
      $display("FAIL timeout_resp: starts=%0d n=%0d ack=%b err=%b rdata=%h required 1 %0d 001 1 00",
               o.start_cnt, o.ack_n, o.ack_v, o.err, o.rdata, TO + 2); miscompares++;
    end
    mdl_ptr = 1;
    set_fields(2, 2'b11, 2'b10, 2'b01, 8'hC3);
    req = 3'b100;
    run_txn(1'b0, 3, 8'h96, -1, 50, o);
    vectors++;
    if (o.ack_n !== 5 || o.ack_v !== 3'b100 || o.err !== 1'b0 || o.rdata !== 8'h96 || o.s_cs !== 2'b11) begin
      $display("FAIL timeout_next: n=%0d ack=%b err=%b rdata=%h cs=%b required 5 100 0 96 11",
               o.ack_n, o.ack_v, o.err, o.rdata, o.s_cs); miscompares++;
    end
    mdl_ptr = 0;
  endtask

  task automatic test_invalid_select();
    obs_t o; int g;
    set_fields(1, 2'b00, 2'b01, 2'b01, 8'h11);
    req = 3'b010;
    run_txn(1'b0, 2, 8'h00, -1, 20, o);
    vectors++;
    if (o.start_cnt !== 0 || o.ack_n !== 1 || o.ack_v !== 3'b010 || o.err !== 1'b1) begin
      $display("FAIL invalid_cs: starts=%0d n=%0d ack=%b err=%b required 0 1 010 1",
               o.start_cnt, o.ack_n, o.ack_v, o.err); miscompares++;
    end
    mdl_ptr = 2;
    for (int i = 0; i < NREQ; i++) set_fields(i, 2'b01, 2'b00, 2'b00, DW'($urandom));
    req = 3'b111;
    g = rr_pick(req, mdl_ptr);
    run_txn(1'b0, 1, 8'h42, -1, 20, o);
    req = '0;
    vectors++;
    if (o.ack_v !== (3'b001 << g)) begin
      $display("FAIL invalid_ptr: ack=%b required %b", o.ack_v, 3'b001 << g); miscompares++;
    end
    mdl_ptr = (g + 1) % NREQ;
  endtask

  task automatic test_reset_mid_wait();
    obs_t o; int acks; int g;
    set_fields(0, 2'b01, 2'b00, 2'b00, 8'h01);
    req = 3'b001;
    run_txn(1'b0, 2, 8'h10, -1, 20, o);
    mdl_ptr = 1;
    set_fields(2, 2'b11, 2'b01, 2'b10, 8'hE7);
    req = 3'b100;
    acks = 0;
    tick();
    vectors++;
    if (m_start !== 1'b1) begin
      $display("FAIL rstmid_start: m_start=%b required 1", m_start); miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != '0) acks++;
    end
    reset = 1'b1; req = '0;
    tick();
    reset = 1'b0;
    mdl_ptr = 0;
    vectors++;
    if (ack !== '0 || m_cs !== 2'b00 || busy !== 1'b0 || m_start !== 1'b0 || m_wdata !== '0) begin
      $display("FAIL rstmid_outputs: ack=%b cs=%b busy=%b start=%b wdata=%h required 000 00 0 0 00",
               ack, m_cs, busy, m_start, m_wdata); miscompares++;
    end
    m_done = 1'b1; m_rdata = 8'h77;
    tick();
    m_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (ack != '0 || busy !== 1'b0) acks++;
    end
    vectors++;
    if (acks !== 0) begin
      $display("FAIL rstmid_quiet: stray ack/busy cycles=%0d required 0", acks); miscompares++;
    end
    for (int i = 0; i < NREQ; i++) set_fields(i, 2'(i + 1), 2'b00, 2'b00, DW'($urandom));
    req = 3'b111;
    g = rr_pick(req, mdl_ptr);
    run_txn(1'b0, 2, 8'h55, -1, 20, o);
    req = '0;
    vectors++;
    if (o.ack_v !== (3'b001 << g) || o.s_cs !== f_cs[g]) begin
      $display("FAIL rstmid_next: ack=%b cs=%b required %b %b", o.ack_v, o.s_cs, 3'b001 << g, f_cs[g]); miscompares++;
    end
    mdl_ptr = (g + 1) % NREQ;
  endtask

  task automatic test_done_edges();
    obs_t o; int bad;
    bad = 0;
    m_done = 1'b1; m_rdata = 8'hEE;
    tick();
    m_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (ack != '0 || busy !== 1'b0 || m_start !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      $display("FAIL stray_done: reacting cycles=%0d required 0", bad); miscompares++;
    end
    set_fields(1, 2'b01, 2'b11, 2'b01, 8'h24);
    req = 3'b010;
    run_txn(1'b0, TO, 8'h5A, -1, 2*TO, o);
    vectors++;
    if (o.ack_n !== TO + 2 || o.err !== 1'b0 || o.rdata !== 8'h5A || o.ack_v !== 3'b010) begin
      $display("FAIL coincident_done: n=%0d err=%b rdata=%h ack=%b required %0d 0 5a 010",
               o.ack_n, o.err, o.rdata, o.ack_v, TO + 2); miscompares++;
    end
    req = 3'b010;
    run_txn(1'b0, TO + 1, 8'h6B, -1, 2*TO, o);
    vectors++;
    if (o.ack_n !== TO + 2 || o.err !== 1'b1 || o.rdata !== 8'h00 || o.ack_cnt !== 1) begin
      $display("FAIL late_done: n=%0d err=%b rdata=%h acks=%0d required %0d 1 00 1",
               o.ack_n, o.err, o.rdata, o.ack_cnt, TO + 2); miscompares++;
    end
    mdl_ptr = 2;
  endtask

  task automatic test_random();
    obs_t o; int g; int dly; logic [DW-1:0] rd; bit bad;
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1) begin
          set_fields(i, 2'($urandom), 2'($urandom), 2'($urandom), DW'($urandom));
          req[i] = 1'b1;
        end
      end
      if (req == '0) begin
        g = int'($urandom_range(0, NREQ - 1));
        set_fields(g, 2'($urandom), 2'($urandom), 2'($urandom), DW'($urandom));
        req[g] = 1'b1;
      end
      g = rr_pick(req, mdl_ptr);
      dly = int'($urandom_range(1, 6));
      rd = DW'($urandom);
      run_txn(1'b0, dly, rd, g, 60, o);
      bad = 0;
      if (o.ack_v !== (3'b001 << g) || o.ack_cnt !== 1 || o.busy_after !== 1'b0) bad = 1;
      if (f_cs[g] == 2'b00) begin
        if (o.start_cnt !== 0 || o.ack_n !== 1 || o.err !== 1'b1) bad = 1;
      end else begin
        if (o.start_cnt !== 1 || o.ack_n !== dly + 2 || o.err !== 1'b0 || o.rdata !== rd ||
            o.s_cs !== f_cs[g] || o.s_rw !== f_rw[g] || o.s_mode !== f_mode[g] ||
            o.s_wdata !== f_wd[g] || o.hold_ok !== 1'b1 || o.cs_at_ack !== 2'b00) bad = 1;
      end
      vectors++;
      if (bad) begin
        $display("FAIL random_%0d: ack=%b n=%0d err=%b rdata=%h cs=%b wd=%h starts=%0d hold=%b required ack=%b cs=%b wd=%h rdata=%h dly=%0d",
                 t, o.ack_v, o.ack_n, o.err, o.rdata, o.s_cs, o.s_wdata, o.start_cnt, o.hold_ok,
                 3'b001 << g, f_cs[g], f_wd[g], rd, dly); miscompares++;
      end
      mdl_ptr = (g + 1) % NREQ;
    end
    req = '0;
    tick();
  endtask

  initial begin
    reset = 1'b1; req = '0; req_cs = '0; req_rw = '0; req_mode = '0; req_wdata = '0;
    m_done = 1'b0; m_rdata = '0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_invalid_select();
    test_reset_mid_wait();
    test_done_edges();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
